xiyiji_seq: RTL and testbench

- Wash-cycle sequencer for the washer top level.
- Consumes debounced single-cycle button pulses (add, start, emergency) and the 1 Hz tick.
- Holds the programmed wash time and steps the motor through a forward / pause / reverse / pause cycle until the time expires.
- Drives the motor enables, status LEDs, end-of-wash alarm and the remaining-time count that feeds the 7-segment display logic.

---
 rtl/xiyiji_seq.sv | 161 ++++++++++++++++
 tb/tb_xiyiji_seq.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/xiyiji_seq.sv
// Wash-cycle sequencer: programs wash time, runs forward/pause/reverse/pause until time expires.
// Optional build macro XIYIJI_BEEP_EN makes the DONE alarm toggle on every 1 Hz tick.
module xiyiji_seq #(
  parameter int unsigned FWD_S    = 20,
  parameter int unsigned PAUSE_S  = 10,
  parameter int unsigned REV_S    = 20,
  parameter int unsigned ALARM_S  = 5,
  parameter int unsigned MAX_TIME = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       add_p,
  input  logic       start_p,
  input  logic       emergency_p,
  output logic       zheng,
  output logic       fan,
  output logic       ledzheng,
  output logic       ledfan,
  output logic       ledstop,
  output logic       alarm,
  output logic       running,
  output logic [5:0] count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FWD, S_PAUSE1, S_REV, S_PAUSE2, S_HOLD, S_DONE
  } state_t;

  localparam logic [5:0] FWD_T   = 6'(FWD_S);
  localparam logic [5:0] PAUSE_T = 6'(PAUSE_S);
  localparam logic [5:0] REV_T   = 6'(REV_S);
  localparam logic [5:0] ALARM_T = 6'(ALARM_S);
  localparam logic [5:0] MAX_T   = 6'(MAX_TIME);

  state_t     state_q, state_d;
  state_t     saved_q, saved_d;
  logic [5:0] count_q, count_d;
  logic [5:0] timer_q, timer_d;
  logic       zheng_q, zheng_d;
  logic       fan_q, fan_d;
  logic       ledstop_q, ledstop_d;
  logic       alarm_q, alarm_d;
  logic       running_q, running_d;

  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    count_d = count_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (start_p && count_q != 6'd0) begin
          state_d = S_FWD;
          timer_d = FWD_T;
        end else if (add_p) begin
          count_d = (count_q >= MAX_T) ? 6'd0 : count_q + 6'd1;
        end
      end
      S_FWD, S_PAUSE1, S_REV, S_PAUSE2: begin
        if (emergency_p) begin
          saved_d = state_q;
          state_d = S_HOLD;
        end else if (tick_1hz) begin
          count_d = count_q - 6'd1;
          timer_d = timer_q - 6'd1;
          // Wash expiry wins over a phase boundary landing on the same tick.
          if (count_q == 6'd1) begin
            state_d = S_DONE;
            timer_d = ALARM_T;
          end else if (timer_q == 6'd1) begin
            case (state_q)
              S_FWD:    begin state_d = S_PAUSE1; timer_d = PAUSE_T; end
              S_PAUSE1: begin state_d = S_REV;    timer_d = REV_T;   end
              S_REV:    begin state_d = S_PAUSE2; timer_d = PAUSE_T; end
              default:  begin state_d = S_FWD;    timer_d = FWD_T;   end
            endcase
          end
        end
      end
      S_HOLD: begin
        if (emergency_p) begin
          state_d = S_IDLE;
          count_d = 6'd0;
          timer_d = 6'd0;
        end else if (start_p) begin
          state_d = saved_q;
        end
      end
      S_DONE: begin
        if (emergency_p || start_p) begin
          state_d = S_IDLE;
          timer_d = 6'd0;
        end else if (tick_1hz) begin
          if (timer_q == 6'd1) begin
            state_d = S_IDLE;
            timer_d = 6'd0;
          end else begin
            timer_d = timer_q - 6'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = 6'd0;
        timer_d = 6'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register together with it.
  always_comb begin
    zheng_d   = (state_d == S_FWD);
    fan_d     = (state_d == S_REV);
    ledstop_d = !(state_d == S_FWD || state_d == S_REV);
    running_d = (state_d == S_FWD) || (state_d == S_PAUSE1) ||
                (state_d == S_REV) || (state_d == S_PAUSE2);
`ifdef XIYIJI_BEEP_EN
    if (state_d != S_DONE)      alarm_d = 1'b0;
    else if (state_q != S_DONE) alarm_d = 1'b1;
    else if (tick_1hz)          alarm_d = ~alarm_q;
    else                        alarm_d = alarm_q;
`else
    alarm_d = (state_d == S_DONE);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      saved_q   <= S_FWD;
      count_q   <= 6'd0;
      timer_q   <= 6'd0;
      zheng_q   <= 1'b0;
      fan_q     <= 1'b0;
      ledstop_q <= 1'b1;
      alarm_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      saved_q   <= saved_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      zheng_q   <= zheng_d;
      fan_q     <= fan_d;
      ledstop_q <= ledstop_d;
      alarm_q   <= alarm_d;
      running_q <= running_d;
    end
  end

  assign zheng    = zheng_q;
  assign fan      = fan_q;
  assign ledzheng = zheng_q;
  assign ledfan   = fan_q;
  assign ledstop  = ledstop_q;
  assign alarm    = alarm_q;
  assign running  = running_q;
  assign count    = count_q;

endmodule

// File: tb/tb_xiyiji_seq.sv
// Table-driven bench for xiyiji_seq with short test timings; honours XIYIJI_BEEP_EN for alarm expectations.
module tb_xiyiji_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0, add_p = 1'b0, start_p = 1'b0, emergency_p = 1'b0;
  logic       zheng, fan, ledzheng, ledfan, ledstop, alarm, running;
  logic [5:0] count;

  int checks = 0;
  int errors = 0;

  localparam int ST_IDLE = 0, ST_FWD = 1, ST_P1 = 2, ST_REV = 3, ST_P2 = 4, ST_HOLD = 5, ST_DONE = 6;
  localparam logic [3:0] N = 4'b0000, ADD = 4'b1000, STA = 4'b0100, EMG = 4'b0010, TCK = 4'b0001;
`ifdef XIYIJI_BEEP_EN
  localparam logic ALT = 1'b0;
`else
  localparam logic ALT = 1'b1;
`endif

  typedef struct {
    logic [3:0] stim;
    int         st;
    logic       al;
    logic [5:0] cnt;
  } vec_t;

  vec_t vecs[$];

  xiyiji_seq #(.FWD_S(3), .PAUSE_S(2), .REV_S(3), .ALARM_S(4), .MAX_TIME(59)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .add_p(add_p), .start_p(start_p),
    .emergency_p(emergency_p), .zheng(zheng), .fan(fan), .ledzheng(ledzheng),
    .ledfan(ledfan), .ledstop(ledstop), .alarm(alarm), .running(running), .count(count)
  );

  always #5 clk = ~clk;

  // Expected {zheng, fan, ledzheng, ledfan, ledstop, alarm, running} for a state.
  function automatic logic [6:0] exp_outs(input int st, input logic al);
    logic z, f, r;
    z = (st == ST_FWD);
    f = (st == ST_REV);
    r = (st >= ST_FWD) && (st <= ST_P2);
    return {z, f, z, f, !(z || f), al, r};
  endfunction

  task automatic pv(input logic [3:0] stim, input int st, input logic al, input int cnt);
    vec_t v;
    v.stim = stim;
    v.st   = st;
    v.al   = al;
    v.cnt  = 6'(cnt);
    vecs.push_back(v);
  endtask

  task automatic check_outs(input string name, input logic [12:0] exp);
    logic [12:0] act;
    act = {zheng, fan, ledzheng, ledfan, ledstop, alarm, running, count};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b (z f lz lf ls al run count)", name, act, exp);
    end
    checks++;
    if (zheng && fan) begin
      errors++;
      $display("FAIL %s_excl: got zheng=1 fan=1 want not both", name);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    {add_p, start_p, emergency_p, tick_1hz} = v.stim;
    @(posedge clk);
    #1;
    {add_p, start_p, emergency_p, tick_1hz} = N;
    check_outs($sformatf("vec%0d", idx), {exp_outs(v.st, v.al), v.cnt});
  endtask

  initial begin
    int sts[12];
    sts = '{ST_FWD, ST_FWD, ST_P1, ST_P1, ST_REV, ST_REV, ST_REV, ST_P2, ST_P2, ST_FWD, ST_FWD, ST_DONE};

    // 16 adds, start, emergency abort
    for (int i = 1; i <= 16; i++) pv(ADD, ST_IDLE, 0, i);
    pv(STA, ST_FWD, 0, 16);
    pv(N,   ST_FWD, 0, 16);
    pv(EMG, ST_HOLD, 0, 16);
    pv(EMG, ST_IDLE, 0, 0);
    // full cycle from 12 with alarm tail
    for (int i = 1; i <= 12; i++) pv(ADD, ST_IDLE, 0, i);
    pv(STA, ST_FWD, 0, 12);
    for (int k = 0; k < 12; k++) pv(TCK, sts[k], (k == 11), 11 - k);
    pv(TCK, ST_DONE, ALT, 0);
    pv(TCK, ST_DONE, 1, 0);
    pv(TCK, ST_DONE, ALT, 0);
    pv(TCK, ST_IDLE, 0, 0);
    // emergency hold in REV, resume with frozen timers
    for (int i = 1; i <= 12; i++) pv(ADD, ST_IDLE, 0, i);
    pv(STA, ST_FWD, 0, 12);
    for (int k = 0; k < 5; k++) pv(TCK, sts[k], 0, 11 - k);
    pv(EMG, ST_HOLD, 0, 7);
    for (int k = 0; k < 5; k++) pv(TCK, ST_HOLD, 0, 7);
    pv(STA, ST_REV, 0, 7);
    pv(TCK, ST_REV, 0, 6);
    pv(TCK, ST_REV, 0, 5);
    pv(TCK, ST_P2, 0, 4);
    pv(EMG, ST_HOLD, 0, 4);
    pv(EMG, ST_IDLE, 0, 0);
    pv(STA, ST_IDLE, 0, 0);
    // wrap at MAX_TIME, add ignored while running, emergency beats start
    for (int i = 1; i <= 59; i++) pv(ADD, ST_IDLE, 0, i);
    pv(ADD, ST_IDLE, 0, 0);
    pv(ADD, ST_IDLE, 0, 1);
    pv(ADD, ST_IDLE, 0, 2);
    pv(STA, ST_FWD, 0, 2);
    pv(ADD, ST_FWD, 0, 2);
    pv(EMG | STA, ST_HOLD, 0, 2);
    pv(TCK, ST_HOLD, 0, 2);
    pv(STA, ST_FWD, 0, 2);
    pv(TCK, ST_FWD, 0, 1);
    pv(TCK, ST_DONE, 1, 0);
    pv(STA, ST_IDLE, 0, 0);
    // emergency ignored in IDLE, emergency exits DONE early
    pv(ADD, ST_IDLE, 0, 1);
    pv(EMG, ST_IDLE, 0, 1);
    pv(STA, ST_FWD, 0, 1);
    pv(TCK, ST_DONE, 1, 0);
    pv(EMG, ST_IDLE, 0, 0);

    // reset state
    #12;
    check_outs("reset", {7'b0000100, 6'd0});
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // async reset mid-FWD: outputs drop without a clock edge
    for (int i = 1; i <= 3; i++) apply('{ADD, ST_IDLE, 1'b0, 6'(i)}, 900 + i);
    apply('{STA, ST_FWD, 1'b0, 6'd3}, 904);
    apply('{TCK, ST_FWD, 1'b0, 6'd2}, 905);
    #2;
    rst = 1'b0;
    #1;
    check_outs("async_rst", {7'b0000100, 6'd0});
    @(negedge clk);
    rst = 1'b1;
    apply('{ADD, ST_IDLE, 1'b0, 6'd1}, 906);
    apply('{STA, ST_FWD, 1'b0, 6'd1}, 907);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
